jts16_obj_romrq: RTL and testbench
==================================

Name: jts16_obj_romrq

Overview:
- Responder side of the object ROM fetch interface: answers the sprite draw engine's obj_cs / obj_addr / obj_ok / obj_data requests.
- Serves hits from a 2-entry word cache; misses become single-word reads to the SDRAM controller slot.
- Sits between the object layer and the SDRAM arbiter, one instance per object layer.

Parameters:
- AW, 20, request word-address width (obj_addr).
- SAW, 22, SDRAM word-address width.
- BASE, 22'h0, SDRAM word offset of the object ROM region; added to obj_addr.
- DW, 16, data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- obj_cs  in  1  request valid (level); held until obj_ok is seen
- obj_addr  in  AW  requested word address
- obj_ok  out  1  obj_data valid for the current obj_addr while obj_cs is high
- obj_data  out  DW  returned word
- flush  in  1  invalidate cache (pulse, e.g. on ROM download end)
- sdram_req  out  1  read request to arbiter, held until ack
- sdram_addr  out  SAW  BASE + obj_addr (zero-extended), registered
- sdram_ack  in  1  one-cycle pulse: arbiter accepted request
- sdram_dst  in  1  one-cycle pulse: sdram_din valid
- sdram_din  in  DW  read data

Behaviour:
- Reset (rst_n low, async): state=IDLE; sdram_req=0; sdram_addr=0; obj_ok=0; obj_data=0; both cache valid bits=0; lru=0.
- Cache:
  - Two entries {valid, tag[AW], data[DW]}.
  - lru points to the entry replaced next; lru flips to the other entry on every hit or fill.
- obj_ok:
  - Combinational: obj_cs & (hit on entry0 | hit on entry1), where hit = valid & (tag == obj_addr). obj_data muxes the hit entry.
  - Latency on a hit: obj_ok is high in the same cycle the address is presented.
  - obj_ok is 0 whenever obj_cs=0.
- State IDLE:
  - obj_cs & !hit → latch obj_addr into pend_addr; sdram_addr <= BASE + obj_addr; sdram_req <= 1; go to REQ.
- State REQ:
  - sdram_ack → sdram_req <= 0 in the next cycle; go to WAIT.
  - sdram_req must never drop before ack.
- State WAIT:
  - sdram_dst → write {1, pend_addr, sdram_din} into entry[lru]; flip lru; go to IDLE.
  - The fill is visible next cycle, so miss latency is ack + dst + 1 cycle.
- Address change while pending: the pending read completes and fills normally. If the new address still misses, IDLE immediately starts a new request. No abort on the SDRAM side.
- obj_cs dropping mid-request: the request still completes and the fill happens. obj_ok stays 0 because obj_cs=0.
- sdram_ack and sdram_dst in the same cycle while in REQ: treat as ack followed by dst. Fill immediately and return to IDLE.
- flush:
  - Clears both valid bits in the next cycle.
  - If flush arrives in WAIT, the in-flight fill is discarded: valid stays 0 for that entry.
  - flush has priority over a simultaneous fill.
- Address arithmetic: BASE + obj_addr is computed modulo 2^SAW; wrap at the top of SDRAM is allowed.
- Only one outstanding SDRAM request at a time.

Decomposition:
- Shared package jts16_obj_pkg:
  - state encoding localparams IDLE/REQ/WAIT;
  - default AW/SAW/DW constants, shared with the draw block.
- Optional sub-module jts16_obj_romrq_cache: 2-entry tag/data/lru store with lookup and fill ports. The FSM stays in the parent.

Test Plan:
- Cold miss: after reset, obj_cs=1, obj_addr=20'h00123, BASE=22'h100000.
  - Expect sdram_req=1 and sdram_addr=22'h100123 one cycle later, with obj_ok=0.
  - ack at T+3, dst with 16'hBEEF at T+6: obj_ok=1 and obj_data=16'hBEEF at T+7.
- Hit: re-present 20'h00123 → obj_ok=1 in the same cycle, no sdram_req.
- LRU:
  - Fill 20'h00010 and 20'h00011, then hit 10, then miss 20'h00012.
  - 20'h00011 is evicted: re-request of 11 raises sdram_req; re-request of 10 hits.
- Address switch mid-request: change obj_addr from 20'h00020 to 20'h00021 while in WAIT.
  - The 20 fill completes.
  - A second request with sdram_addr=BASE+20'h00021 is issued the cycle after the return to IDLE.
- flush during WAIT: dst arrives with flush=1 in the same cycle → no entry valid afterwards; the same address misses again.
- Reset mid-request: pull rst_n low in REQ → sdram_req=0 and obj_ok=0 immediately; after release, the cache is empty and the next request misses.

Source files
------------

// File: rtl/jts16_obj_pkg.sv
// Shared definitions for the object layer: default bus widths and the
// ROM request FSM state encoding.
package jts16_obj_pkg;

  localparam int OBJ_AW  = 20;
  localparam int OBJ_SAW = 22;
  localparam int OBJ_DW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } obj_state_t;

endpackage

// File: rtl/jts16_obj_romrq_cache.sv
// Two-entry word cache: combinational tag lookup, single-entry fill and a
// one-bit replacement pointer that always names the entry not used last.
module jts16_obj_romrq_cache
  import jts16_obj_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_addr,
  input  logic          i_touch,
  input  logic          i_flush,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_tag,
  input  logic [DW-1:0] i_fill_data,
  output logic          o_hit,
  output logic [DW-1:0] o_data
);

  logic [1:0]    r_valid;
  logic [AW-1:0] r_tag  [2];
  logic [DW-1:0] r_data [2];
  logic          r_lru;

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = r_valid[0] && (r_tag[0] == i_addr);
  assign w_hit1 = r_valid[1] && (r_tag[1] == i_addr);
  assign o_hit  = w_hit0 || w_hit1;
  assign o_data = w_hit0 ? r_data[0] : (w_hit1 ? r_data[1] : '0);

  // Flush outranks a fill landing in the same cycle; a hit only moves the
  // replacement pointer away from the entry that was just used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_lru     <= 1'b0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_fill) begin
      r_valid[r_lru] <= 1'b1;
      r_tag[r_lru]   <= i_fill_tag;
      r_data[r_lru]  <= i_fill_data;
      r_lru          <= ~r_lru;
    end else if (i_touch && o_hit) begin
      r_lru <= w_hit0;
    end
  end

endmodule

// File: rtl/jts16_obj_romrq.sv
// Object ROM responder: serves sprite word reads from a 2-entry cache and
// turns misses into single-word SDRAM reads, one outstanding at a time.
module jts16_obj_romrq
  import jts16_obj_pkg::*;
#(
  parameter int             AW   = OBJ_AW,
  parameter int             SAW  = OBJ_SAW,
  parameter logic [SAW-1:0] BASE = '0,
  parameter int             DW   = OBJ_DW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_obj_cs,
  input  logic [AW-1:0]  i_obj_addr,
  output logic           o_obj_ok,
  output logic [DW-1:0]  o_obj_data,
  input  logic           i_flush,
  output logic           o_sdram_req,
  output logic [SAW-1:0] o_sdram_addr,
  input  logic           i_sdram_ack,
  input  logic           i_sdram_dst,
  input  logic [DW-1:0]  i_sdram_din
);

  obj_state_t     r_state;
  logic           r_sdram_req;
  logic [SAW-1:0] r_sdram_addr;
  logic [AW-1:0]  r_pend_addr;
  logic           r_discard;

  logic          w_hit;
  logic [DW-1:0] w_cache_data;
  logic          w_fill;
  logic          w_fill_en;

  // Data may arrive together with the ack, so a fill is possible from REQ too.
  assign w_fill    = i_sdram_dst &&
                     ((r_state == WAIT) || ((r_state == REQ) && i_sdram_ack));
  assign w_fill_en = w_fill && !r_discard;

  jts16_obj_romrq_cache #(
    .AW (AW),
    .DW (DW)
  ) u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr      (i_obj_addr),
    .i_touch     (i_obj_cs),
    .i_flush     (i_flush),
    .i_fill      (w_fill_en),
    .i_fill_tag  (r_pend_addr),
    .i_fill_data (i_sdram_din),
    .o_hit       (w_hit),
    .o_data      (w_cache_data)
  );

  assign o_obj_ok     = i_obj_cs && w_hit;
  assign o_obj_data   = w_cache_data;
  assign o_sdram_req  = r_sdram_req;
  assign o_sdram_addr = r_sdram_addr;

  // A flush seen while a read is in flight marks its data as stale so the
  // eventual fill is dropped instead of resurrecting pre-flush contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sdram_req  <= 1'b0;
      r_sdram_addr <= '0;
      r_pend_addr  <= '0;
      r_discard    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_obj_cs && !w_hit) begin
            r_pend_addr  <= i_obj_addr;
            r_sdram_addr <= BASE + SAW'(i_obj_addr);
            r_sdram_req  <= 1'b1;
            r_discard    <= 1'b0;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (i_flush) r_discard <= 1'b1;
          if (i_sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_state     <= i_sdram_dst ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (i_flush) r_discard <= 1'b1;
          if (i_sdram_dst) r_state <= IDLE;
        end
        default: begin
          r_sdram_req <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jts16_obj_romrq.sv
// Bench for jts16_obj_romrq: directed scenarios followed by random traffic,
// all checked against a transaction-level cache/request model.
module tb_jts16_obj_romrq;

  localparam logic [21:0] BASE = 22'h100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        objCs = 1'b0;
  logic [19:0] objAddr = '0;
  logic        objOk;
  logic [15:0] objData;
  logic        flush = 1'b0;
  logic        sdramReq;
  logic [21:0] sdramAddr;
  logic        sdramAck = 1'b0;
  logic        sdramDst = 1'b0;
  logic [15:0] sdramDin = '0;

  int total = 0;
  int bad = 0;

  // Reference state: cache contents, replacement pointer and outstanding read
  bit          mValid [2];
  logic [19:0] mTag   [2];
  logic [15:0] mData  [2];
  int          mLru;
  bit          mBusy, mReqOut, mAcked, mDiscard;
  logic [19:0] mPend;
  logic [21:0] mReqAddr;

  logic        obsOk, obsReq;
  logic [15:0] obsData;
  logic [21:0] obsAddr;

  jts16_obj_romrq #(
    .AW   (20),
    .SAW  (22),
    .BASE (BASE),
    .DW   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_obj_cs     (objCs),
    .i_obj_addr   (objAddr),
    .o_obj_ok     (objOk),
    .o_obj_data   (objData),
    .i_flush      (flush),
    .o_sdram_req  (sdramReq),
    .o_sdram_addr (sdramAddr),
    .i_sdram_ack  (sdramAck),
    .i_sdram_dst  (sdramDst),
    .i_sdram_din  (sdramDin)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelLookup(input logic [19:0] addr);
    for (int i = 0; i < 2; i++)
      if (mValid[i] && mTag[i] == addr) return i;
    return -1;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 2; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = '0;
      mData[i]  = '0;
    end
    mLru = 0; mBusy = 0; mReqOut = 0; mAcked = 0; mDiscard = 0;
    mPend = '0; mReqAddr = '0;
  endfunction

  // One clock cycle: drive, sample at negedge, compare, then advance the model
  task automatic applyStimulus(input bit cs, input logic [19:0] addr, input bit fl,
                               input bit ack, input bit dst, input logic [15:0] din);
    int  hitIdx;
    bit  expOk, fillNow;
    objCs = cs; objAddr = addr; flush = fl;
    sdramAck = ack; sdramDst = dst; sdramDin = din;
    @(negedge clk);
    hitIdx = modelLookup(addr);
    expOk  = cs && (hitIdx >= 0);
    obsOk = objOk; obsData = objData; obsReq = sdramReq; obsAddr = sdramAddr;
    checkOutput("obj_ok", 32'(obsOk), 32'(expOk));
    if (expOk) checkOutput("obj_data", 32'(obsData), 32'(mData[hitIdx]));
    checkOutput("sdram_req", 32'(obsReq), 32'(mReqOut));
    checkOutput("sdram_addr", 32'(obsAddr), 32'(mReqAddr));

    fillNow = mBusy && dst && (mAcked || ack);
    if (fl) begin
      mValid[0] = 1'b0;
      mValid[1] = 1'b0;
    end else if (fillNow && !mDiscard) begin
      mValid[mLru] = 1'b1;
      mTag[mLru]   = mPend;
      mData[mLru]  = din;
      mLru         = 1 - mLru;
    end else if (expOk) begin
      mLru = 1 - hitIdx;
    end

    if (!mBusy) begin
      if (cs && hitIdx < 0) begin
        mBusy = 1; mReqOut = 1; mAcked = 0; mDiscard = 0;
        mPend = addr;
        mReqAddr = BASE + {2'b00, addr};
      end
    end else begin
      if (fl) mDiscard = 1;
      if (ack) begin
        mReqOut = 0;
        mAcked  = 1;
      end
      if (fillNow) mBusy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the outputs settle at once, releases
  task automatic applyReset();
    rst_n = 1'b0;
    #2;
    modelClear();
    checkOutput("rst_obj_ok", 32'(objOk), 32'd0);
    checkOutput("rst_obj_data", 32'(objData), 32'd0);
    checkOutput("rst_sdram_req", 32'(sdramReq), 32'd0);
    checkOutput("rst_sdram_addr", 32'(sdramAddr), 32'd0);
    objCs = 0; flush = 0; sdramAck = 0; sdramDst = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic missFill(input logic [19:0] addr, input logic [15:0] data);
    applyStimulus(1, addr, 0, 0, 0, 0);
    applyStimulus(1, addr, 0, 1, 0, 0);
    applyStimulus(1, addr, 0, 0, 1, data);
  endtask

  logic [19:0] pool [6];
  logic [19:0] curAddr;
  bit          rCs, rFl, rAck, rDst;

  initial begin
    pool[0] = 20'h00010; pool[1] = 20'h00011; pool[2] = 20'h00012;
    pool[3] = 20'h00013; pool[4] = 20'hFFFFF; pool[5] = 20'h80000;
    modelClear();
    @(posedge clk);
    #1;
    applyReset();

    // Cold miss with the documented arbiter timing
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    checkOutput("cold_ok_T", 32'(obsOk), 32'd0);
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    checkOutput("cold_req_T1", 32'(obsReq), 32'd1);
    checkOutput("cold_addr_T1", 32'(obsAddr), 32'h100123);
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    applyStimulus(1, 20'h00123, 0, 1, 0, 0);
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    checkOutput("cold_req_drop", 32'(obsReq), 32'd0);
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    applyStimulus(1, 20'h00123, 0, 0, 1, 16'hBEEF);
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    checkOutput("cold_ok_T7", 32'(obsOk), 32'd1);
    checkOutput("cold_data_T7", 32'(obsData), 32'hBEEF);

    // Repeat hit: same-cycle ok and no new request
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    applyStimulus(1, 20'h00123, 0, 0, 0, 0);
    checkOutput("hit_ok", 32'(obsOk), 32'd1);
    checkOutput("hit_noreq", 32'(obsReq), 32'd0);
    applyStimulus(0, 20'h00123, 0, 0, 0, 0);
    checkOutput("nocs_ok", 32'(obsOk), 32'd0);

    // Replacement order: 11 is evicted by 12 after 10 was touched
    applyStimulus(0, 0, 1, 0, 0, 0);
    missFill(20'h00010, 16'h1010);
    missFill(20'h00011, 16'h1111);
    applyStimulus(1, 20'h00010, 0, 0, 0, 0);
    checkOutput("lru_hit10", 32'(obsOk), 32'd1);
    missFill(20'h00012, 16'h1212);
    applyStimulus(1, 20'h00011, 0, 0, 0, 0);
    checkOutput("lru_miss11", 32'(obsOk), 32'd0);
    applyStimulus(1, 20'h00010, 0, 0, 0, 0);
    checkOutput("lru_req11", 32'(obsReq), 32'd1);
    checkOutput("lru_hit10b", 32'(obsOk), 32'd1);
    applyStimulus(1, 20'h00011, 0, 1, 1, 16'h2222);

    // Address switch while the first read is in WAIT
    missFill(20'h00020, 16'h2020);
    applyStimulus(1, 20'h00020, 0, 0, 0, 0);
    applyStimulus(1, 20'h00030, 0, 0, 0, 0);
    applyStimulus(1, 20'h00030, 0, 1, 0, 0);
    applyStimulus(1, 20'h00021, 0, 0, 0, 0);
    applyStimulus(1, 20'h00021, 0, 0, 1, 16'h3030);
    applyStimulus(1, 20'h00021, 0, 0, 0, 0);
    checkOutput("switch_idle_noreq", 32'(obsReq), 32'd0);
    applyStimulus(1, 20'h00030, 0, 0, 0, 0);
    checkOutput("switch_req", 32'(obsReq), 32'd1);
    checkOutput("switch_addr", 32'(obsAddr), 32'h100021);
    checkOutput("switch_fill30", 32'(obsOk), 32'd1);
    applyStimulus(1, 20'h00021, 0, 1, 1, 16'h2121);

    // Flush landing together with the data return
    applyStimulus(1, 20'h00040, 0, 0, 0, 0);
    applyStimulus(1, 20'h00040, 0, 1, 0, 0);
    applyStimulus(1, 20'h00040, 1, 0, 1, 16'h4040);
    applyStimulus(1, 20'h00040, 0, 0, 0, 0);
    checkOutput("flush_miss", 32'(obsOk), 32'd0);
    applyStimulus(1, 20'h00021, 0, 0, 0, 0);
    checkOutput("flush_rereq", 32'(obsReq), 32'd1);
    checkOutput("flush_empty", 32'(obsOk), 32'd0);
    applyStimulus(1, 20'h00040, 0, 1, 1, 16'h4141);

    // Reset while a request is waiting for its ack
    applyStimulus(1, 20'h00050, 0, 0, 0, 0);
    applyStimulus(1, 20'h00040, 0, 0, 0, 0);
    checkOutput("prerst_hit", 32'(obsOk), 32'd1);
    objCs = 1; objAddr = 20'h00040;
    applyReset();
    applyStimulus(1, 20'h00040, 0, 0, 0, 0);
    checkOutput("postrst_miss", 32'(obsOk), 32'd0);
    applyStimulus(1, 20'h00040, 0, 0, 0, 0);
    checkOutput("postrst_req", 32'(obsReq), 32'd1);

    // Random traffic against the model, with a model-driven arbiter
    curAddr = pool[0];
    for (int c = 0; c < 4000; c++) begin
      rCs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) curAddr = pool[$urandom_range(0, 5)];
      rFl  = ($urandom_range(0, 63) == 0);
      rAck = 0;
      rDst = 0;
      if (mReqOut) begin
        rAck = ($urandom_range(0, 2) == 0);
        rDst = rAck && ($urandom_range(0, 3) == 0);
      end else if (mBusy && mAcked) begin
        rDst = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(rCs, curAddr, rFl, rAck, rDst, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
